// File: rtl/e_mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the E_Mem tile single-port memory.
// Define E_MEM_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module e_mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              UserCLK,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    owner;
  logic                    we_q;
  logic [3:0]              cnt;
  logic                    grant;
  logic                    fire;
  logic [1:0]              rsp_valid;
  logic [1:0][DATA_W-1:0]  rsp_rdata;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef E_MEM_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // ready is qualified by valid so an idle port with no requests shows all-zero outputs
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;
  assign fire       = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_rdata = rsp_rdata[0];
  assign rsp1_rdata = rsp_rdata[1];

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (fire) begin
          owner      <= grant;
          last_grant <= grant;
          we_q       <= grant ? req1_we : req0_we;
          // mem_addr/mem_wdata double as the request latch and hold between accesses
          mem_addr   <= grant ? req1_addr  : req0_addr;
          mem_wdata  <= grant ? req1_wdata : req0_wdata;
          mem_en     <= 1'b1;
          mem_we     <= grant ? req1_we : req0_we;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (we_q) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata[owner] <= '0;
            state            <= RESP;
          end else begin
            cnt   <= 4'(READ_LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_rdata[owner] <= mem_rdata;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
